// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - register offsets, FSM encoding and CAUSE layout for irq_controller
package irq_pkg;

    localparam logic [3:0] OFS_PEND  = 4'h0;
    localparam logic [3:0] OFS_MASK  = 4'h4;
    localparam logic [3:0] OFS_CTRL  = 4'h8;
    localparam logic [3:0] OFS_CAUSE = 4'hC;

    localparam logic [1:0] IRQ_IDLE    = 2'd0;
    localparam logic [1:0] IRQ_ASSERT  = 2'd1;
    localparam logic [1:0] IRQ_SERVICE = 2'd2;

    localparam int CAUSE_VALID_BIT = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder; idx reads 0 when nothing is requested
module irq_prio_enc #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic [2:0]       idx,
    output logic             valid
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[2:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - memory-mapped interrupt controller with one-shot irq handshake
// Optional IRQ_LEVEL_TRIG_EN adds per-source level triggering via CTRL[8 +: N_SRC].
module irq_controller
    import irq_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0020
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [N_SRC-1:0] src,
    input  logic             in_kernel,
    output logic             irq
);

    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic             gie_q, gie_d;
    logic             irq_q, irq_d;
    logic [1:0]       state_q, state_d;

    logic             sel, wr_pend, wr_mask, wr_ctrl;
    logic [N_SRC-1:0] evt, active, trig;
    logic [2:0]       cause_idx;
    logic             cause_valid;
    logic             req;
    logic             unused_wdata;

    assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_pend = wr & sel & (addr[3:0] == OFS_PEND);
    assign wr_mask = wr & sel & (addr[3:0] == OFS_MASK);
    assign wr_ctrl = wr & sel & (addr[3:0] == OFS_CTRL);

    assign evt    = src & ~src_q;
    assign active = pend_q & mask_q;
    assign req    = gie_q & (|active);

    assign unused_wdata = ^wdata;

`ifdef IRQ_LEVEL_TRIG_EN
    logic [N_SRC-1:0] trig_q, trig_d;

    assign trig_d = wr_ctrl ? wdata[8 +: N_SRC] : trig_q;
    assign trig   = trig_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q <= '0;
        end else begin
            trig_q <= trig_d;
        end
    end
`else
    assign trig = '0;
`endif

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio (
        .req   (active),
        .idx   (cause_idx),
        .valid (cause_valid)
    );

    // Sets are OR-ed in after the W1C so a same-cycle event always survives.
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) begin
            pend_d = pend_d & ~wdata[N_SRC-1:0];
        end
        pend_d = pend_d | evt | (trig & src);
        mask_d = wr_mask ? wdata[N_SRC-1:0] : mask_q;
        gie_d  = wr_ctrl ? wdata[0] : gie_q;
        src_d  = src;
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        case (state_q)
            IRQ_IDLE: begin
                irq_d = 1'b0;
                if (req && !in_kernel) begin
                    state_d = IRQ_ASSERT;
                    irq_d   = 1'b1;
                end
            end
            IRQ_ASSERT: begin
                if (in_kernel) begin
                    state_d = IRQ_SERVICE;
                    irq_d   = 1'b0;
                end else if (!req) begin
                    state_d = IRQ_IDLE;
                    irq_d   = 1'b0;
                end
            end
            IRQ_SERVICE: begin
                irq_d = 1'b0;
                if (!in_kernel) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q  <= '0;
            mask_q  <= '0;
            src_q   <= '0;
            gie_q   <= 1'b0;
            irq_q   <= 1'b0;
            state_q <= IRQ_IDLE;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            src_q   <= src_d;
            gie_q   <= gie_d;
            irq_q   <= irq_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && sel) begin
            case (addr[3:0])
                OFS_PEND:  rdata[N_SRC-1:0] = pend_q;
                OFS_MASK:  rdata[N_SRC-1:0] = mask_q;
                OFS_CTRL: begin
                    rdata[0]          = gie_q;
                    rdata[8 +: N_SRC] = trig;
                end
                OFS_CAUSE: begin
                    rdata[CAUSE_VALID_BIT] = cause_valid;
                    rdata[2:0]             = cause_idx;
                end
                default: rdata = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed plus randomized bench for irq_controller against a behavioural model
module tb_irq_controller;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        in_kernel = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [N-1:0] src = '0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    bit m_pend [N];
    bit m_mask [N];
    bit m_trig [N];
    bit m_srcq [N];
    bit m_gie;
    bit m_irq;
    bit m_busy;

    irq_controller #(
        .N_SRC     (N),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .src       (src),
        .in_kernel (in_kernel),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_req();
        bit any = 0;
        for (int i = 0; i < N; i++) any = any | (m_pend[i] & m_mask[i]);
        return m_gie & any;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] v = '0;
        bit found = 0;
        if ((a >> 4) != (BASE >> 4)) return '0;
        case (a[3:0])
            4'h0: for (int i = 0; i < N; i++) v[i] = m_pend[i];
            4'h4: for (int i = 0; i < N; i++) v[i] = m_mask[i];
            4'h8: begin
                v[0] = m_gie;
`ifdef IRQ_LEVEL_TRIG_EN
                for (int i = 0; i < N; i++) v[8 + i] = m_trig[i];
`endif
            end
            4'hC: for (int i = 0; i < N; i++) begin
                if (!found && m_pend[i] && m_mask[i]) begin
                    v = 32'h8000_0000 + 32'(i);
                    found = 1;
                end
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_trig[i] = 0; m_srcq[i] = 0;
        end
        m_gie = 0; m_irq = 0; m_busy = 0;
    endtask

    // One clock edge of the model, from the inputs presented during the cycle.
    task automatic m_clock();
        bit r;
        bit hit;
        bit set;
        r = m_req();
        if (m_busy) begin
            if (!in_kernel) m_busy = 0;
        end else if (m_irq) begin
            if (in_kernel) begin
                m_irq = 0; m_busy = 1;
            end else if (!r) begin
                m_irq = 0;
            end
        end else if (r && !in_kernel) begin
            m_irq = 1;
        end
        hit = wr && ((addr >> 4) == (BASE >> 4));
        for (int i = 0; i < N; i++) begin
            set = src[i] && !m_srcq[i];
`ifdef IRQ_LEVEL_TRIG_EN
            set = set || (m_trig[i] && src[i]);
`endif
            m_pend[i] = set || (m_pend[i] && !(hit && addr[3:0] == 4'h0 && wdata[i]));
            if (hit && addr[3:0] == 4'h4) m_mask[i] = wdata[i];
            if (hit && addr[3:0] == 4'h8) m_trig[i] = wdata[8 + i];
            m_srcq[i] = src[i];
        end
        if (hit && addr[3:0] == 4'h8) m_gie = wdata[0];
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("irq", 32'(irq), 32'(m_irq));
        if (rd) chk("rdata", rdata, m_read(addr));
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] ofs, input logic [31:0] d);
        wr = 1; addr = BASE + 32'(ofs); wdata = d;
        cycle();
        wr = 0; wdata = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] ofs, input logic [31:0] exp);
        rd = 1; addr = BASE + 32'(ofs);
        #1;
        chk(tag, rdata, exp);
        chk({tag, "_model"}, rdata, m_read(addr));
        rd = 0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;

        rd_chk("rst_pend", 4'h0, 32'h0);
        rd_chk("rst_mask", 4'h4, 32'h0);
        rd_chk("rst_ctrl", 4'h8, 32'h0);
        rd_chk("rst_cause", 4'hC, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        wr_reg(4'h4, 32'h2);
        wr_reg(4'h8, 32'h1);
        src = 4'b0010;
        cycle();
        src = '0;
        rd_chk("pend_after_k", 4'h0, 32'h2);
        chk("irq_after_k", 32'(irq), 32'h0);
        cycle();
        chk("irq_after_k1", 32'(irq), 32'h1);
        rd_chk("cause_src1", 4'hC, 32'h8000_0001);

        in_kernel = 1;
        cycle();
        chk("irq_entry_drop", 32'(irq), 32'h0);
        wr_reg(4'h0, 32'h2);
        in_kernel = 0;
        cycle();
        chk("irq_after_exit", 32'(irq), 32'h0);
        cycle();
        chk("irq_idle", 32'(irq), 32'h0);
        rd_chk("pend_cleared", 4'h0, 32'h0);

        wr_reg(4'h4, 32'hF);
        src = 4'b1100;
        cycle();
        src = '0;
        rd_chk("cause_prio", 4'hC, 32'h8000_0002);
        wr_reg(4'h0, 32'h4);
        rd_chk("cause_next", 4'hC, 32'h8000_0003);
        wr_reg(4'h0, 32'h8);
        rd_chk("cause_none", 4'hC, 32'h0);

        wr = 1; addr = BASE; wdata = 32'h1; src = 4'b0001;
        cycle();
        wr = 0; wdata = '0;
        rd_chk("set_wins", 4'h0, 32'h1);
        repeat (4) cycle();
        wr_reg(4'h0, 32'h1);
        repeat (4) cycle();
        rd_chk("held_no_reset", 4'h0, 32'h0);
        src = '0;
        cycle();

        src = 4'b0001;
        cycle();
        src = '0;
        cycle();
        chk("irq_before_rst", 32'(irq), 32'h1);
        @(posedge clk);
        #3 reset = 0;
        #1;
        chk("irq_async_rst", 32'(irq), 32'h0);
        m_reset();
        rd_chk("arst_pend", 4'h0, 32'h0);
        rd_chk("arst_mask", 4'h4, 32'h0);
        rd_chk("arst_ctrl", 4'h8, 32'h0);
        rd_chk("arst_cause", 4'hC, 32'h0);
        @(posedge clk);
        #1 reset = 1;

        for (int n = 0; n < 400; n++) begin
            logic [3:0] ofs;
            ofs = 4'(($urandom_range(0, 3)) * 4);
            src = N'($urandom_range(0, 3) == 0 ? $urandom : src);
            if ($urandom_range(0, 7) == 0) in_kernel = ~in_kernel;
            wr = ($urandom_range(0, 3) == 0);
            rd = $urandom_range(0, 1);
            addr = ($urandom_range(0, 9) == 0) ? BASE + 32'h10 + 32'(ofs) : BASE + 32'(ofs);
            wdata = $urandom;
            if (wr && ofs == 4'h8 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
            cycle();
        end
        wr = 0; rd = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
